axi_read_arbiter: RTL and testbench

- Shares the single SoC AXI-full read channel between the instruction-fetch requester (IFU) and the data-memory requester (MEM).
- Each requester uses the team's AXI-lite-style read interface: address valid/ready, 64-bit data valid/ready.
- The block accepts one request, issues it as a single-beat AXI read, and routes the response back to the owner.
- Round-robin grant; only one outstanding transaction at a time.

---
 rtl/axi_read_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
//
// Purpose:
//   Shares one AXI-full read channel between two requesters: the instruction
//   fetch unit (IFU) and the data memory stage (MEM). One request is accepted
//   at a time, issued as a single-beat AXI read, and its response is routed
//   back to the requester that owns it. Ties are broken round-robin, and MEM
//   wins the first tie after reset.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   IFU_* / MEM_*                requester side: address valid/ready with
//                                size, 64-bit read data valid/ready
//   io_master_ar*                AXI read-address channel (single beat, INCR)
//   io_master_r*                 AXI read-data channel
//   ARBITER_error_signal         error flag from the last completed response
//                                (bad rresp or an rid that does not match)
// -----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] MEM_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] IFU_raddr,
    input  logic [2:0]  IFU_rsize,
    input  logic        IFU_raddr_valid,
    output logic        IFU_raddr_ready,
    output logic [63:0] IFU_rdata,
    output logic        IFU_rdata_valid,
    input  logic        IFU_rdata_ready,

    input  logic [31:0] MEM_raddr,
    input  logic [2:0]  MEM_rsize,
    input  logic        MEM_raddr_valid,
    output logic        MEM_raddr_ready,
    output logic [63:0] MEM_rdata,
    output logic        MEM_rdata_valid,
    input  logic        MEM_rdata_ready,

    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [63:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,

    output logic        ARBITER_error_signal
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        owner_mem_q, owner_mem_d;   // 1: MEM owns the transaction
    logic        last_mem_q, last_mem_d;     // 1: MEM was served last
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        error_q, error_d;

    logic        sel_mem_s;
    logic        idle_s;
    logic        addr_phase_s;
    logic        data_phase_s;
    logic        owner_rdy_s;
    logic [3:0]  arid_s;
    logic        r_hs_s;

    // Phase decode; every handshake output is held low while reset is high.
    always_comb begin
        idle_s       = (state_q == ST_IDLE) && !rst;
        addr_phase_s = (state_q == ST_ADDR) && !rst;
        data_phase_s = (state_q == ST_DATA) && !rst;
    end

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        sel_mem_s = 1'b0;
        if (IFU_raddr_valid && MEM_raddr_valid) begin
            sel_mem_s = !last_mem_q;
        end else if (MEM_raddr_valid) begin
            sel_mem_s = 1'b1;
        end else begin
            sel_mem_s = 1'b0;
        end
    end

    // Owner-dependent selects shared by the outputs and the next-state logic.
    always_comb begin
        owner_rdy_s = owner_mem_q ? MEM_rdata_ready : IFU_rdata_ready;
        arid_s      = owner_mem_q ? MEM_ID : IFU_ID;
        r_hs_s      = data_phase_s && io_master_rvalid && owner_rdy_s;
    end

    // Requester and AXI outputs; the data path is a zero-latency passthrough.
    always_comb begin
        IFU_raddr_ready      = idle_s && IFU_raddr_valid && !sel_mem_s;
        MEM_raddr_ready      = idle_s && MEM_raddr_valid && sel_mem_s;
        IFU_rdata            = io_master_rdata;
        MEM_rdata            = io_master_rdata;
        IFU_rdata_valid      = data_phase_s && !owner_mem_q && io_master_rvalid;
        MEM_rdata_valid      = data_phase_s && owner_mem_q && io_master_rvalid;
        io_master_arvalid    = addr_phase_s;
        io_master_araddr     = addr_q;
        io_master_arsize     = size_q;
        io_master_arid       = arid_s;
        io_master_arlen      = 8'd0;
        io_master_arburst    = 2'b01;
        io_master_rready     = data_phase_s && owner_rdy_s;
        ARBITER_error_signal = error_q;
    end

    // Next-state logic for the IDLE -> ADDR -> DATA transaction sequence.
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        last_mem_d  = last_mem_q;
        addr_d      = addr_q;
        size_d      = size_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                // Ready is combinational on valid, so any valid is a handshake.
                if (idle_s && (IFU_raddr_valid || MEM_raddr_valid)) begin
                    owner_mem_d = sel_mem_s;
                    addr_d      = sel_mem_s ? MEM_raddr : IFU_raddr;
                    size_d      = sel_mem_s ? MEM_rsize : IFU_rsize;
                    state_d     = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (io_master_arready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                // A beat without rlast keeps the owner in DATA (defensive).
                if (r_hs_s && io_master_rlast) begin
                    state_d    = ST_IDLE;
                    last_mem_d = owner_mem_q;
                    error_d    = (io_master_rresp != 2'b00) || (io_master_rid != arid_s);
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; the pointer starts as "IFU last".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_mem_q <= 1'b0;
            last_mem_q  <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 3'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            last_mem_q  <= last_mem_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Self-checking bench for axi_read_arbiter. Inputs change on the falling edge
// and outputs are sampled 1 ns later, well before the next rising edge. The
// reference model works at transaction level: it tracks which requester has
// priority on a tie and what the error flag should be after each completion.
// -----------------------------------------------------------------------------
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] IFU_raddr;
    logic [2:0]  IFU_rsize;
    logic        IFU_raddr_valid;
    logic        IFU_raddr_ready;
    logic [63:0] IFU_rdata;
    logic        IFU_rdata_valid;
    logic        IFU_rdata_ready;
    logic [31:0] MEM_raddr;
    logic [2:0]  MEM_rsize;
    logic        MEM_raddr_valid;
    logic        MEM_raddr_ready;
    logic [63:0] MEM_rdata;
    logic        MEM_rdata_valid;
    logic        MEM_rdata_ready;
    logic        io_master_arready;
    logic        io_master_arvalid;
    logic [31:0] io_master_araddr;
    logic [3:0]  io_master_arid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rready;
    logic        io_master_rvalid;
    logic [1:0]  io_master_rresp;
    logic [63:0] io_master_rdata;
    logic        io_master_rlast;
    logic [3:0]  io_master_rid;
    logic        ARBITER_error_signal;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit m_prio_mem = 1'b1;   // MEM wins the next tie
    bit m_error    = 1'b0;

    axi_read_arbiter #(.IFU_ID(4'd0), .MEM_ID(4'd1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .IFU_raddr           (IFU_raddr),
        .IFU_rsize           (IFU_rsize),
        .IFU_raddr_valid     (IFU_raddr_valid),
        .IFU_raddr_ready     (IFU_raddr_ready),
        .IFU_rdata           (IFU_rdata),
        .IFU_rdata_valid     (IFU_rdata_valid),
        .IFU_rdata_ready     (IFU_rdata_ready),
        .MEM_raddr           (MEM_raddr),
        .MEM_rsize           (MEM_rsize),
        .MEM_raddr_valid     (MEM_raddr_valid),
        .MEM_raddr_ready     (MEM_raddr_ready),
        .MEM_rdata           (MEM_rdata),
        .MEM_rdata_valid     (MEM_rdata_valid),
        .MEM_rdata_ready     (MEM_rdata_ready),
        .io_master_arready   (io_master_arready),
        .io_master_arvalid   (io_master_arvalid),
        .io_master_araddr    (io_master_araddr),
        .io_master_arid      (io_master_arid),
        .io_master_arlen     (io_master_arlen),
        .io_master_arsize    (io_master_arsize),
        .io_master_arburst   (io_master_arburst),
        .io_master_rready    (io_master_rready),
        .io_master_rvalid    (io_master_rvalid),
        .io_master_rresp     (io_master_rresp),
        .io_master_rdata     (io_master_rdata),
        .io_master_rlast     (io_master_rlast),
        .io_master_rid       (io_master_rid),
        .ARBITER_error_signal(ARBITER_error_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        check(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    // All requester/AXI handshake outputs must be low.
    task automatic check_quiet(input string tag);
        check_b({tag, "_ifu_ardy"}, IFU_raddr_ready, 1'b0);
        check_b({tag, "_mem_ardy"}, MEM_raddr_ready, 1'b0);
        check_b({tag, "_ifu_rvld"}, IFU_rdata_valid, 1'b0);
        check_b({tag, "_mem_rvld"}, MEM_rdata_valid, 1'b0);
        check_b({tag, "_arvalid"},  io_master_arvalid, 1'b0);
        check_b({tag, "_rready"},   io_master_rready, 1'b0);
    endtask

    // One full transaction, entered and left just after a falling edge.
    // ar_wait: cycles arvalid is held before arready; rdy_wait: cycles the
    // owner holds rdata_ready low while rvalid is up. abort: reset in DATA.
    task automatic txn(input bit iv, input bit mv,
                       input logic [31:0] ia, input logic [2:0] isz,
                       input logic [31:0] ma, input logic [2:0] msz,
                       input int ar_wait, input int rdy_wait,
                       input logic [1:0] resp, input bit bad_id,
                       input logic [63:0] data, input bit abort);
        bit          win_mem;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic [3:0]  exp_id;
        win_mem  = (iv && mv) ? m_prio_mem : mv;
        exp_addr = win_mem ? ma : ia;
        exp_size = win_mem ? msz : isz;
        exp_id   = win_mem ? 4'd1 : 4'd0;

        IFU_raddr = ia;  IFU_rsize = isz;  IFU_raddr_valid = iv;
        MEM_raddr = ma;  MEM_rsize = msz;  MEM_raddr_valid = mv;
        IFU_rdata_ready = 1'b0;  MEM_rdata_ready = 1'b0;
        io_master_arready = 1'b0;  io_master_rvalid = 1'b0;  io_master_rlast = 1'b0;
        #1;
        check_b("grant_ifu_ardy", IFU_raddr_ready, iv && !win_mem);
        check_b("grant_mem_ardy", MEM_raddr_ready, mv && win_mem);
        check_b("grant_arvalid", io_master_arvalid, 1'b0);
        @(negedge clk);

        // Accepted: winner drops valid, addresses change and must be ignored.
        if (win_mem) MEM_raddr_valid = 1'b0;
        else         IFU_raddr_valid = 1'b0;
        IFU_raddr = $urandom;  MEM_raddr = $urandom;
        IFU_rsize = 3'($urandom_range(0, 7));  MEM_rsize = 3'($urandom_range(0, 7));
        for (int k = 0; k <= ar_wait; k++) begin
            io_master_arready = (k == ar_wait);
            #1;
            check_b("addr_arvalid", io_master_arvalid, 1'b1);
            check("addr_araddr", {32'd0, io_master_araddr}, {32'd0, exp_addr});
            check("addr_arsize", {61'd0, io_master_arsize}, {61'd0, exp_size});
            check("addr_arid", {60'd0, io_master_arid}, {60'd0, exp_id});
            check("addr_arlen", {56'd0, io_master_arlen}, 64'd0);
            check("addr_arburst", {62'd0, io_master_arburst}, 64'd1);
            check_b("addr_ifu_ardy", IFU_raddr_ready, 1'b0);
            check_b("addr_mem_ardy", MEM_raddr_ready, 1'b0);
            check_b("addr_rready", io_master_rready, 1'b0);
            @(negedge clk);
        end

        io_master_arready = 1'b0;
        io_master_rvalid  = 1'b1;
        io_master_rdata   = data;
        io_master_rresp   = resp;
        io_master_rid     = bad_id ? (exp_id ^ 4'hA) : exp_id;
        io_master_rlast   = 1'b1;
        for (int k = 0; k <= rdy_wait; k++) begin
            // The non-owner is always ready; rready must not follow it.
            IFU_rdata_ready = win_mem ? 1'b1 : (k == rdy_wait);
            MEM_rdata_ready = win_mem ? (k == rdy_wait) : 1'b1;
            #1;
            check_b("data_arvalid", io_master_arvalid, 1'b0);
            check_b("data_rready", io_master_rready, k == rdy_wait);
            check_b("data_ifu_rvld", IFU_rdata_valid, !win_mem);
            check_b("data_mem_rvld", MEM_rdata_valid, win_mem);
            check("data_rdata", win_mem ? MEM_rdata : IFU_rdata, data);
            check_b("data_ifu_ardy", IFU_raddr_ready, 1'b0);
            check_b("data_mem_ardy", MEM_raddr_ready, 1'b0);
            check_b("data_error_hold", ARBITER_error_signal, m_error);
            if (abort) begin
                IFU_raddr_valid = 1'b1;  MEM_raddr_valid = 1'b1;
                IFU_rdata_ready = 1'b1;  MEM_rdata_ready = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                #1;
                check_quiet("in_rst");
                rst = 1'b0;
                IFU_raddr_valid = 1'b0;  MEM_raddr_valid = 1'b0;
                #1;
                check_quiet("after_rst");
                m_error = 1'b0;
                m_prio_mem = 1'b1;
                check_b("after_rst_error", ARBITER_error_signal, m_error);
                io_master_rvalid = 1'b0;  io_master_rlast = 1'b0;
                IFU_rdata_ready = 1'b0;  MEM_rdata_ready = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end

        io_master_rvalid = 1'b0;  io_master_rlast = 1'b0;
        IFU_rdata_ready = 1'b0;  MEM_rdata_ready = 1'b0;
        m_error    = (resp != 2'b00) || bad_id;
        m_prio_mem = !win_mem;
        #1;
        check_b("done_error", ARBITER_error_signal, m_error);
        check_b("done_arvalid", io_master_arvalid, 1'b0);
        check_b("done_rready", io_master_rready, 1'b0);
        check_b("done_ifu_rvld", IFU_rdata_valid, 1'b0);
        check_b("done_mem_rvld", MEM_rdata_valid, 1'b0);
        // A waiting loser is granted in the first IDLE cycle, not before.
        check_b("done_ifu_ardy", IFU_raddr_ready, IFU_raddr_valid);
        check_b("done_mem_ardy", MEM_raddr_ready, MEM_raddr_valid);
    endtask

    initial begin
        rst = 1'b1;
        IFU_raddr = 32'd0;  IFU_rsize = 3'd0;  IFU_raddr_valid = 1'b1;  IFU_rdata_ready = 1'b1;
        MEM_raddr = 32'd0;  MEM_rsize = 3'd0;  MEM_raddr_valid = 1'b1;  MEM_rdata_ready = 1'b1;
        io_master_arready = 1'b1;  io_master_rvalid = 1'b1;  io_master_rresp = 2'b00;
        io_master_rdata = 64'd0;  io_master_rlast = 1'b1;  io_master_rid = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check_b("reset_error", ARBITER_error_signal, 1'b0);
        rst = 1'b0;
        IFU_raddr_valid = 1'b0;  MEM_raddr_valid = 1'b0;
        io_master_rvalid = 1'b0;  io_master_arready = 1'b0;  io_master_rlast = 1'b0;
        #1;
        check_quiet("idle_no_req");
        @(negedge clk);

        // Tie right after reset: MEM first, then the waiting IFU.
        txn(1'b1, 1'b1, 32'h0000_1000, 3'd3, 32'h0000_2000, 3'd3, 0, 0, 2'b00, 1'b0, 64'hAAAA_0000_0000_0001, 1'b0);
        txn(1'b1, 1'b0, 32'h0000_1000, 3'd3, 32'h0, 3'd0, 0, 0, 2'b00, 1'b0, 64'hAAAA_0000_0000_0002, 1'b0);

        // MEM alone, arready delayed 3 cycles.
        txn(1'b0, 1'b1, 32'h0, 3'd0, 32'h8000_0010, 3'd2, 3, 0, 2'b00, 1'b0, 64'h1122_3344_5566_7788, 1'b0);

        // Both requesting continuously: grants alternate.
        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 1'b1, $urandom, 3'd2, $urandom, 3'd3, 0, 0, 2'b00, 1'b0, {$urandom, $urandom}, 1'b0);
        end

        // Owner holds rdata_ready low for 2 cycles.
        txn(1'b1, 1'b0, 32'h0000_4000, 3'd2, 32'h0, 3'd0, 1, 2, 2'b00, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);

        // Error flag: SLVERR, then rid mismatch, then clean.
        txn(1'b0, 1'b1, 32'h0, 3'd0, 32'h0000_5000, 3'd3, 0, 0, 2'b10, 1'b0, 64'h1, 1'b0);
        txn(1'b1, 1'b0, 32'h0000_6000, 3'd3, 32'h0, 3'd0, 0, 0, 2'b00, 1'b1, 64'h2, 1'b0);
        txn(1'b0, 1'b1, 32'h0, 3'd0, 32'h0000_7000, 3'd3, 0, 0, 2'b00, 1'b0, 64'h3, 1'b0);

        // Leave the error flag set, then reset in the middle of DATA.
        txn(1'b1, 1'b0, 32'h0000_8000, 3'd3, 32'h0, 3'd0, 0, 0, 2'b11, 1'b0, 64'h4, 1'b0);
        txn(1'b1, 1'b1, 32'h0000_9000, 3'd3, 32'h0000_A000, 3'd3, 1, 1, 2'b00, 1'b0, 64'h5, 1'b1);

        // After the mid-transaction reset MEM again wins the first tie.
        txn(1'b1, 1'b1, 32'h0000_B000, 3'd1, 32'h0000_C000, 3'd1, 0, 0, 2'b00, 1'b0, 64'h6, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int   r;
            r = int'($urandom_range(1, 3));
            txn((r & 1) != 0, (r & 2) != 0,
                $urandom, 3'($urandom_range(0, 3)),
                $urandom, 3'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                {$urandom, $urandom}, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
